// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        WRITE,
        WSTART,
        WEND
    } state_e;

    localparam int BYTES_NORMAL = 1;
    localparam int BYTES_BURST  = 4;
    localparam int MODE_BIT     = 31;
    localparam int DEF_BAUDBITS = 9;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_idx
);

    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        // Upper segment first, then wrap to the bottom of the vector.
        for (int i = 0; i < NREQ; i++) begin
            if (!found && (i >= int'(ptr)) && req[i]) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART core transmitter among NREQ requesters;
// reprograms BRG/MODE only when the shadowed settings differ from the request.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int BAUDBITS = DEF_BAUDBITS,
    parameter int TMO      = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   word,
    input  logic [NREQ-1:0]      burst,
    input  logic [BAUDBITS-1:0]  baud,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic [2:0]           owner,
    output logic                 tmo_err,
    output logic [31:0]          core_d,
    output logic                 core_wrbaud,
    output logic                 core_wrtx,
    input  logic                 core_tend
);

    localparam int CW = $clog2(TMO) + 1;

    state_e              state_q, state_d;
    logic [2:0]          owner_q, owner_d;
    logic [2:0]          ptr_q, ptr_d;
    logic                sh_valid_q, sh_valid_d;
    logic                sh_mode_q, sh_mode_d;
    logic [BAUDBITS-1:0] sh_baud_q, sh_baud_d;
    logic                tmo_err_q, tmo_err_d;
    logic [2:0]          sent_q, sent_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         word_q, word_d;
    logic                burst_q, burst_d;
    logic [BAUDBITS-1:0] baud_q, baud_d;
    logic [2:0]          need_q, need_d;

    logic [NREQ-1:0]     gnt;
    logic [2:0]          gnt_idx;
    logic                cfg_needed;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign cfg_needed = !sh_valid_q || (sh_mode_q != burst_q) || (sh_baud_q != baud_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            sh_valid_q <= 1'b0;
            sh_mode_q  <= 1'b0;
            sh_baud_q  <= '0;
            tmo_err_q  <= 1'b0;
            sent_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            sh_valid_q <= sh_valid_d;
            sh_mode_q  <= sh_mode_d;
            sh_baud_q  <= sh_baud_d;
            tmo_err_q  <= tmo_err_d;
            sent_q     <= sent_d;
            cnt_q      <= cnt_d;
        end
    end

    // Captured request payload; only meaningful once a grant has loaded it.
    always_ff @(posedge clk) begin
        word_q  <= word_d;
        burst_q <= burst_d;
        baud_q  <= baud_d;
        need_q  <= need_d;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        sh_valid_d = sh_valid_q;
        sh_mode_d  = sh_mode_q;
        sh_baud_d  = sh_baud_q;
        tmo_err_d  = tmo_err_q;
        sent_d     = sent_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        burst_d    = burst_q;
        baud_d     = baud_q;
        need_d     = need_q;
        case (state_q)
            IDLE: begin
                if ((|req) && core_tend) begin
                    state_d = CFG;
                    owner_d = gnt_idx;
                    ptr_d   = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
                    baud_d  = baud;
                    for (int i = 0; i < NREQ; i++) begin
                        if (gnt[i]) begin
                            word_d  = word[32*i +: 32];
                            burst_d = burst[i];
                        end
                    end
                end
            end
            CFG: begin
                if (cfg_needed) begin
                    sh_valid_d = 1'b1;
                    sh_mode_d  = burst_q;
                    sh_baud_d  = baud_q;
                end
                state_d = WRITE;
            end
            WRITE: begin
                need_d  = burst_q ? 3'(BYTES_BURST) : 3'(BYTES_NORMAL);
                sent_d  = '0;
                cnt_d   = '0;
                state_d = WSTART;
            end
            WSTART: begin
                if (!core_tend) begin
                    state_d = WEND;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    tmo_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WEND: begin
                if (core_tend) begin
                    sent_d = sent_q + 3'd1;
                    if (sent_q + 3'd1 == need_q) begin
                        state_d = IDLE;
                    end else begin
                        // Inter-byte tend gap: restart the start window for the next byte.
                        cnt_d   = '0;
                        state_d = WSTART;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack         = '0;
        core_d      = '0;
        core_wrbaud = 1'b0;
        core_wrtx   = 1'b0;
        case (state_q)
            CFG: begin
                if (cfg_needed) begin
                    core_wrbaud              = 1'b1;
                    core_d[BAUDBITS-1:0]     = baud_q;
                    core_d[MODE_BIT]         = burst_q;
                end
            end
            WRITE: begin
                core_wrtx = 1'b1;
                core_d    = word_q;
                for (int i = 0; i < NREQ; i++) begin
                    if (owner_q == 3'(i)) ack[i] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign owner   = owner_q;
    assign tmo_err = tmo_err_q;

endmodule
